// File: rtl/line_fill_buffer.sv
// line_fill_buffer: fetches one 32-byte line as four 64-bit beats and writes it to one of four data-array ways.
// Revision 1.0
`default_nettype none

module line_fill_buffer #(
   parameter int ADDR_WIDTH      = 13,
   parameter int LINE_ADDR_WIDTH = 27
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fill_req,
   input  logic [LINE_ADDR_WIDTH-1:0] fill_line_addr,
   input  logic [1:0]                 fill_way,
   output logic                       fill_busy,
   output logic                       fill_done,
   output logic                       mem_req_valid,
   input  logic                       mem_req_ready,
   output logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                       mem_rsp_valid,
   input  logic [63:0]                mem_rsp_data,
   output logic [3:0]                 dsram_write,
   output logic [ADDR_WIDTH-1:0]      dsram_a,
   output logic [31:0]                dsram_be,
   output logic [255:0]               dsram_wd
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_BEAT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                     state_q;
   logic [1:0]                 beat_q;
   logic [LINE_ADDR_WIDTH-1:0] addr_q;
   logic [1:0]                 way_q;
   logic [255:0]               wd_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         beat_q  <= 2'd0;
         addr_q  <= '0;
         way_q   <= 2'd0;
         wd_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fill_req) begin
                  addr_q  <= fill_line_addr;
                  way_q   <= fill_way;
                  beat_q  <= 2'd0;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_req_ready) state_q <= S_BEAT;
            end
            S_BEAT: begin
               // Beats land in ascending 64-bit lanes; the fourth beat completes the line.
               if (mem_rsp_valid) begin
                  wd_q[{beat_q, 6'd0} +: 64] <= mem_rsp_data;
                  beat_q <= beat_q + 2'd1;
                  if (beat_q == 2'd3) state_q <= S_WRITE;
               end
            end
            S_WRITE: state_q <= S_DONE;
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign fill_busy     = (state_q != S_IDLE);
   assign fill_done     = (state_q == S_DONE);
   assign mem_req_valid = (state_q == S_REQ);
   assign mem_req_addr  = addr_q;
   assign dsram_write   = (state_q == S_WRITE) ? (4'b0001 << way_q) : 4'b0000;
   assign dsram_a       = addr_q[ADDR_WIDTH-1:0];
   assign dsram_be      = 32'hFFFF_FFFF;
   assign dsram_wd      = wd_q;

endmodule

`default_nettype wire

// File: tb/tb_line_fill_buffer.sv
// Directed self-checking bench for line_fill_buffer.
// Revision 1.0
`default_nettype none

module tb_line_fill_buffer;

   logic         clk = 1'b0;
   logic         reset;
   logic         fill_req;
   logic [26:0]  fill_line_addr;
   logic [1:0]   fill_way;
   logic         fill_busy;
   logic         fill_done;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic [26:0]  mem_req_addr;
   logic         mem_rsp_valid;
   logic [63:0]  mem_rsp_data;
   logic [3:0]   dsram_write;
   logic [12:0]  dsram_a;
   logic [31:0]  dsram_be;
   logic [255:0] dsram_wd;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int done_cnt = 0;

   line_fill_buffer #(.ADDR_WIDTH(13), .LINE_ADDR_WIDTH(27)) dut (
      .clk            (clk),
      .reset          (reset),
      .fill_req       (fill_req),
      .fill_line_addr (fill_line_addr),
      .fill_way       (fill_way),
      .fill_busy      (fill_busy),
      .fill_done      (fill_done),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .dsram_write    (dsram_write),
      .dsram_a        (dsram_a),
      .dsram_be       (dsram_be),
      .dsram_wd       (dsram_wd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle monitor: counts write strobes and done pulses, enforces one-hot strobe.
   always @(negedge clk) begin
      if (fill_done) done_cnt++;
      if (dsram_write != 4'b0000) wr_cnt++;
      chk("write_onehot", 256'($countones(dsram_write) <= 1), 256'd1);
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},  fill_busy,     0);
      chk({tag, "_done"},  fill_done,     0);
      chk({tag, "_mvld"},  mem_req_valid, 0);
      chk({tag, "_maddr"}, mem_req_addr,  0);
      chk({tag, "_wr"},    dsram_write,   0);
      chk({tag, "_a"},     dsram_a,       0);
      chk({tag, "_wd"},    dsram_wd,      0);
      chk({tag, "_be"},    dsram_be,      256'h0FFFF_FFFF);
   endtask

   // Runs one complete fill starting in IDLE; returns in IDLE one cycle after fill_done.
   task automatic run_fill(input string tag, input logic [26:0] addr, input logic [1:0] way,
                           input int stall, input int gap, input bit spur, input bit poke,
                           input logic [63:0] base);
      logic [255:0] exp_wd;
      int wr0, dn0;
      exp_wd = {base + 64'd3, base + 64'd2, base + 64'd1, base};
      wr0 = wr_cnt;
      dn0 = done_cnt;
      fill_req = 1'b1; fill_line_addr = addr; fill_way = way;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      tick();
      fill_req = 1'b0; fill_line_addr = 27'h7FF_FFFF; fill_way = 2'd3;
      for (int i = 0; i <= stall; i++) begin
         chk({tag, "_req_valid"}, mem_req_valid, 1);
         chk({tag, "_req_addr"},  mem_req_addr,  addr);
         mem_req_ready = (i == stall);
         mem_rsp_valid = spur;
         mem_rsp_data  = 64'hDEAD_BEEF_0000_0000 + 64'(i);
         tick();
      end
      mem_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gap; g++) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
            tick();
         end
         chk({tag, "_beat_mvld"}, mem_req_valid, 0);
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = base + 64'(k);
         if (poke && k == 1) begin
            fill_req = 1'b1; fill_way = 2'd0; fill_line_addr = 27'h555_5555;
         end
         tick();
         fill_req = 1'b0;
      end
      mem_rsp_valid = spur;
      mem_rsp_data  = 64'hFEED_FACE_CAFE_F00D;
      chk({tag, "_write"}, dsram_write, 4'b0001 << way);
      chk({tag, "_a"},     dsram_a,     addr[12:0]);
      chk({tag, "_wd"},    dsram_wd,    exp_wd);
      chk({tag, "_wdone"}, fill_done,   0);
      tick();
      chk({tag, "_done"},   fill_done,   1);
      chk({tag, "_dwrite"}, dsram_write, 0);
      chk({tag, "_dwd"},    dsram_wd,    exp_wd);
      tick();
      mem_rsp_valid = 1'b0;
      chk({tag, "_idle_done"}, fill_done, 0);
      chk({tag, "_idle_busy"}, fill_busy, 0);
      chk({tag, "_wr_count"},   256'(wr_cnt - wr0),   1);
      chk({tag, "_done_count"}, 256'(done_cnt - dn0), 1);
   endtask

   initial begin
      int wr0, dn0;
      reset = 1'b1; fill_req = 1'b0; fill_line_addr = '0; fill_way = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      tick(); tick();
      reset = 1'b0;
      check_reset_outputs("reset");

      // Basic fill at minimum latency, explicit cycle numbering.
      fill_req = 1'b1; fill_line_addr = 27'h0000123; fill_way = 2'd2; mem_req_ready = 1'b1;
      tick(); // cycle 1
      fill_req = 1'b0;
      chk("basic_c1_busy", fill_busy, 1);
      chk("basic_c1_mvld", mem_req_valid, 1);
      chk("basic_c1_maddr", mem_req_addr, 27'h0000123);
      tick(); // cycle 2
      chk("basic_c2_mvld", mem_req_valid, 0);
      for (int k = 0; k < 4; k++) begin
         mem_rsp_valid = 1'b1; mem_rsp_data = 64'(k);
         tick();
      end
      mem_rsp_valid = 1'b0; // cycle 6
      chk("basic_c6_write", dsram_write, 4'b0100);
      chk("basic_c6_a", dsram_a, 13'h0123);
      chk("basic_c6_wd", dsram_wd, {64'd3, 64'd2, 64'd1, 64'd0});
      chk("basic_c6_be", dsram_be, 32'hFFFF_FFFF);
      tick(); // cycle 7
      chk("basic_c7_done", fill_done, 1);
      chk("basic_c7_write", dsram_write, 0);
      tick(); // cycle 8
      chk("basic_c8_done", fill_done, 0);
      chk("basic_c8_busy", fill_busy, 0);

      run_fill("stall", 27'h0000123, 2'd2, 5, 0, 1'b1, 1'b0, 64'd0);
      run_fill("gaps",  27'h0000123, 2'd2, 0, 2, 1'b1, 1'b0, 64'd0);
      run_fill("busy",  27'h1ABCDEF, 2'd3, 0, 1, 1'b0, 1'b1, 64'h1111_0000_0000_0000);

      // Abort after three beats; reset competes with fill_req and a response beat.
      wr0 = wr_cnt; dn0 = done_cnt;
      fill_req = 1'b1; fill_line_addr = 27'h0000777; fill_way = 2'd1; mem_req_ready = 1'b1;
      tick(); fill_req = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         mem_rsp_valid = 1'b1; mem_rsp_data = 64'hAAAA_0000_0000_0000 + 64'(k);
         tick();
      end
      reset = 1'b1; fill_req = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hAAAA_0000_0000_0003;
      tick();
      reset = 1'b0; fill_req = 1'b0; mem_rsp_valid = 1'b0;
      check_reset_outputs("abort");
      tick(); tick(); tick();
      chk("abort_idle_busy", fill_busy, 0);
      chk("abort_wr_count",   256'(wr_cnt - wr0),   0);
      chk("abort_done_count", 256'(done_cnt - dn0), 0);
      run_fill("after_abort", 27'h0000777, 2'd1, 0, 0, 1'b0, 1'b0, 64'h2222_0000_0000_0000);

      for (int w = 0; w < 4; w++)
         run_fill("b2b", 27'h0100000 + 27'(w * 3), 2'(w), 0, 0, 1'b0, 1'b0,
                  64'h3000_0000_0000_0000 + (64'(w) << 48));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
